regfile_param: RTL

//  Parametrised register file: NUM_REGS x DATA_W, two combinational read ports,
//  one write port with valid/ready handshake. Hardwired zero register.

---
 rtl/regfile_param_if.sv | 26 ++
 rtl/regfile_param.sv | 110 +++++++++++
 2 files changed

// File: rtl/regfile_param_if.sv
// Register file bus: one valid/ready write channel, two combinational read ports, clear-busy flag.
// The master modport is the CPU side (decode reads, writeback writes); the slave modport is the register file.
interface regfile_param_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr1;
  logic [DATA_W-1:0] rd_data1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data2;
  logic              busy;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_addr1, rd_addr2,
    input  wr_ready, rd_data1, rd_data2, busy
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_addr1, rd_addr2,
    output wr_ready, rd_data1, rd_data2, busy
  );
endinterface

// File: rtl/regfile_param.sv
// NUM_REGS x DATA_W flop register file, hardwired zero reg, post-reset clear engine; REGFILE_FWD_EN adds write-to-read bypass.
// Reads are zero-latency combinational, writes commit on the accepting edge; wr_ready is low during reset and the NUM_REGS-cycle clear.
module regfile_param #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic            clk,
  input  logic            reset,
  regfile_param_if.slave  bus
);

  typedef enum logic {CLEAR, RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic              run;
  logic              wr_fire;
  logic              wr_ok;
  logic [DATA_W-1:0] rd_data1_c;
  logic [DATA_W-1:0] rd_data2_c;

  // Index maps to real storage: in range and not the hardwired zero register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (32'(a) < 32'(NUM_REGS)) && (32'(a) != 32'(ZERO_REG));
  endfunction

  // Reset is folded in so the port reads as idle while reset is held low.
  assign run          = (state_q == RUN) && reset;
  assign bus.wr_ready = run;
  assign bus.busy     = !run;
  assign wr_fire      = bus.wr_valid && run;
  assign wr_ok        = wr_fire && addr_ok(bus.wr_addr);

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (32'(clr_ptr_q) == 32'(NUM_REGS - 1)) begin
          state_d   = RUN;
          clr_ptr_d = '0;
        end
      end
      RUN: begin
        state_d   = RUN;
        clr_ptr_d = '0;
      end
      default: begin
        state_d   = CLEAR;
        clr_ptr_d = '0;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if ((state_q == CLEAR) && (clr_ptr_q == ADDR_W'(i))) begin
        regs_d[i] = '0;
      end else if (wr_ok && (bus.wr_addr == ADDR_W'(i))) begin
        regs_d[i] = bus.wr_data;
      end
    end
  end

  always_comb begin
    rd_data1_c = '0;
    rd_data2_c = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.rd_addr1 == ADDR_W'(i)) rd_data1_c = regs_q[i];
      if (bus.rd_addr2 == ADDR_W'(i)) rd_data2_c = regs_q[i];
    end
    if (!addr_ok(bus.rd_addr1)) rd_data1_c = '0;
    if (!addr_ok(bus.rd_addr2)) rd_data2_c = '0;
`ifdef REGFILE_FWD_EN
    // wr_ok already excludes the zero register and out-of-range indices.
    if (wr_ok && (bus.wr_addr == bus.rd_addr1)) rd_data1_c = bus.wr_data;
    if (wr_ok && (bus.wr_addr == bus.rd_addr2)) rd_data2_c = bus.wr_data;
`endif
    if (!run) begin
      rd_data1_c = '0;
      rd_data2_c = '0;
    end
  end

  assign bus.rd_data1 = rd_data1_c;
  assign bus.rd_data2 = rd_data2_c;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Storage has no reset of its own; the clear engine zeroes it after reset.
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

endmodule
